// File: rtl/dac_seq_pkg.sv
// dac_seq_pkg
//   Shared types and constants for the DAC sample sequencer slice.
//   - BYTES_PER_FRAME / SAMPLE_WIDTH : frame geometry of the host stream
//   - dac_frame_t                    : one left/right sample pair (ch1 in the upper bits)
//   - dac_seq_state_t                : conversion handshake states
//   - pack_frame()                   : builds a frame from its four stream bytes
package dac_seq_pkg;

  localparam int BYTES_PER_FRAME = 4;
  localparam int SAMPLE_WIDTH    = 12;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] ch1;
    logic [SAMPLE_WIDTH-1:0] ch2;
  } dac_frame_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    CONV = 2'd2
  } dac_seq_state_t;

  // The upper nibbles of b0 and b2 carry no sample data and are dropped.
  function automatic dac_frame_t pack_frame(input logic [3:0] b0_lo,
                                            input logic [7:0] b1,
                                            input logic [3:0] b2_lo,
                                            input logic [7:0] b3);
    dac_frame_t f;
    f.ch1 = {b1, b0_lo};
    f.ch2 = {b3, b2_lo};
    return f;
  endfunction

endpackage

// File: rtl/dac_frame_fifo.sv
// dac_frame_fifo
//   Synchronous FIFO of dac_frame_t with registered full/empty/level flags.
//   Ports:
//     clk, reset (async, active-low)
//     flush            : empties the FIFO (pointers and level to zero)
//     push, wr_data    : write a frame (ignored when full)
//     pop              : advance the read pointer (ignored when empty)
//     rd_data          : frame at the head, valid whenever empty is low
//     full, empty      : registered status flags
//     level            : number of frames stored, 0..DEPTH
//   Parameters: DEPTH (power of two, >= 2)
module dac_frame_fifo
  import dac_seq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  dac_frame_t             wr_data,
  input  logic                   pop,
  output dac_frame_t             rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  dac_frame_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LVL_W-1:0] level_next;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_next = level;
    if (do_push && !do_pop) level_next = level + LVL_W'(1);
    else if (do_pop && !do_push) level_next = level - LVL_W'(1);
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end

  // Flags are registered from the next level so that they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_next;
      full  <= (level_next == LVL_W'(DEPTH));
      empty <= (level_next == '0);
    end
  end

endmodule

// File: rtl/dac_sample_sequencer.sv
// dac_sample_sequencer
//   Turns the host USB byte stream into paced conversions for the
//   two-channel 12-bit DAC serializer.
//   Ports:
//     clk, reset (async, active-low)
//     byte_in/byte_valid/byte_ready : stream bytes, 4 per frame
//     enable                        : run; low flushes bytes, FIFO and pacing
//     rate_div                      : sample period minus one, in clk cycles
//     dac_data1/dac_data2           : left/right samples held for the serializer
//     dac_start/dac_done            : conversion request / serializer idle
//     fifo_level                    : frames buffered
//     underrun, late                : one-cycle event pulses
//   Optional build macro DAC_SEQ_STATS_EN adds saturating 16-bit
//   underrun_count and late_count outputs.
module dac_sample_sequencer
  import dac_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    byte_in,
  input  logic                          byte_valid,
  output logic                          byte_ready,
  input  logic                          enable,
  input  logic [DIV_WIDTH-1:0]          rate_div,
  output logic [SAMPLE_WIDTH-1:0]       dac_data1,
  output logic [SAMPLE_WIDTH-1:0]       dac_data2,
  output logic                          dac_start,
  input  logic                          dac_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          late
`ifdef DAC_SEQ_STATS_EN
  ,
  output logic [15:0]                   underrun_count,
  output logic [15:0]                   late_count
`endif
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_FRAME - 1);

  logic [1:0]           byte_idx;
  logic [3:0]           b0_lo;
  logic [7:0]           b1_q;
  logic [3:0]           b2_lo;
  logic                 byte_hs;
  logic                 frame_push;
  dac_frame_t           frame_in;
  dac_frame_t           fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DIV_WIDTH-1:0] tick_cnt;
  logic                 tick;
  logic                 fifo_pop;
  dac_seq_state_t       state;

  // The registered full flag gates only the final byte, so a pop in the
  // same cycle never makes room for that cycle's push.
  assign byte_ready = enable && ((byte_idx != LAST_IDX) || !fifo_full);
  assign byte_hs    = byte_valid && byte_ready;
  assign frame_push = byte_hs && (byte_idx == LAST_IDX);
  assign frame_in   = pack_frame(b0_lo, b1_q, b2_lo, byte_in);

  // Frame assembler: stage b0..b2, b3 goes straight into the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx <= '0;
      b0_lo    <= '0;
      b1_q     <= '0;
      b2_lo    <= '0;
    end else if (!enable) begin
      byte_idx <= '0;
    end else if (byte_hs) begin
      case (byte_idx)
        2'd0:    b0_lo <= byte_in[3:0];
        2'd1:    b1_q  <= byte_in;
        2'd2:    b2_lo <= byte_in[3:0];
        default: ;
      endcase
      byte_idx <= byte_idx + 2'd1;
    end
  end

  dac_frame_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (!enable),
    .push    (frame_push),
    .wr_data (frame_in),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Rate divider. The >= wrap keeps the counter sane if rate_div is lowered
  // below the current count.
  assign tick = enable && (tick_cnt == rate_div);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (!enable || (tick_cnt >= rate_div)) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + DIV_WIDTH'(1);
    end
  end

  // A start is only issued from IDLE with the serializer reporting idle.
  assign fifo_pop = (state == IDLE) && tick && !fifo_empty && dac_done;

  // Conversion handshake: start, wait for the serializer to go busy, then
  // wait for it to come back idle. Ticks while busy are reported as late.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      dac_data1 <= '0;
      dac_data2 <= '0;
      dac_start <= 1'b0;
      underrun  <= 1'b0;
      late      <= 1'b0;
    end else begin
      dac_start <= 1'b0;
      underrun  <= 1'b0;
      late      <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            dac_data1 <= fifo_head.ch1;
            dac_data2 <= fifo_head.ch2;
            dac_start <= 1'b1;
            state     <= ACK;
          end else if (tick && fifo_empty) begin
            underrun <= 1'b1;
          end
        end
        ACK: begin
          if (tick) late <= 1'b1;
          if (!dac_done) state <= CONV;
        end
        CONV: begin
          if (tick) late <= 1'b1;
          if (dac_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DAC_SEQ_STATS_EN
  logic enable_q;
  logic enable_rise;

  assign enable_rise = enable && !enable_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) enable_q <= 1'b0;
    else        enable_q <= enable;
  end

  // Event counters saturate rather than wrap; re-enabling starts a fresh run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underrun_count <= '0;
      late_count     <= '0;
    end else if (enable_rise) begin
      underrun_count <= '0;
      late_count     <= '0;
    end else begin
      if (underrun && (underrun_count != 16'hFFFF)) underrun_count <= underrun_count + 16'd1;
      if (late && (late_count != 16'hFFFF))         late_count     <= late_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// tb_dac_sample_sequencer
//   Directed self-checking bench for dac_sample_sequencer with a behavioural
//   serializer model (fixed-length conversions). Build with DAC_SEQ_STATS_EN
//   to also cover the statistics counters.
module tb_dac_sample_sequencer;

  localparam int FIFO_DEPTH = 16;
  localparam int DIV_WIDTH  = 16;
  localparam int CONV_LEN   = 40;

  logic                        clk = 1'b0;
  logic                        reset = 1'b0;
  logic [7:0]                  byte_in = '0;
  logic                        byte_valid = 1'b0;
  logic                        byte_ready;
  logic                        enable = 1'b0;
  logic [DIV_WIDTH-1:0]        rate_div = '1;
  logic [11:0]                 dac_data1;
  logic [11:0]                 dac_data2;
  logic                        dac_start;
  logic                        dac_done;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                        underrun;
  logic                        late;
`ifdef DAC_SEQ_STATS_EN
  logic [15:0]                 underrun_count;
  logic [15:0]                 late_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  dac_sample_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_WIDTH  (DIV_WIDTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .byte_in        (byte_in),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .enable         (enable),
    .rate_div       (rate_div),
    .dac_data1      (dac_data1),
    .dac_data2      (dac_data2),
    .dac_start      (dac_start),
    .dac_done       (dac_done),
    .fifo_level     (fifo_level),
    .underrun       (underrun)
    ,
    .late           (late)
`ifdef DAC_SEQ_STATS_EN
    ,
    .underrun_count (underrun_count),
    .late_count     (late_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Serializer model: goes busy the edge after a start, idle again CONV_LEN
  // edges later. A start while busy is a protocol violation.
  int conv_rem;
  int violations = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      dac_done <= 1'b1;
      conv_rem <= 0;
    end else if (dac_start) begin
      if (!dac_done) violations <= violations + 1;
      dac_done <= 1'b0;
      conv_rem <= CONV_LEN;
    end else if (conv_rem != 0) begin
      conv_rem <= conv_rem - 1;
      if (conv_rem == 1) dac_done <= 1'b1;
    end
  end

  // Event monitor, sampled mid-cycle.
  int           n_start = 0;
  int           n_late  = 0;
  logic [23:0]  played[$];
  always @(negedge clk) begin
    if (dac_start) begin
      n_start++;
      played.push_back({dac_data1, dac_data2});
    end
    if (late) n_late++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte i of test frame k; upper nibbles of b0/b2 are junk that must be dropped.
  function automatic logic [7:0] frame_byte(input int k, input int i);
    logic [3:0] kk;
    kk = 4'(k);
    case (i)
      0:       return {4'hA, kk};
      1:       return 8'h10 + 8'(k);
      2:       return {4'h5, ~kk};
      default: return 8'hC0 + 8'(k);
    endcase
  endfunction

  function automatic logic [23:0] frame_expect(input int k);
    logic [7:0] b0, b1, b2, b3;
    b0 = frame_byte(k, 0);
    b1 = frame_byte(k, 1);
    b2 = frame_byte(k, 2);
    b3 = frame_byte(k, 3);
    return {b1, b0[3:0], b3, b2[3:0]};
  endfunction

  // Called at edge+1; returns at edge+1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    #0;
    while (!byte_ready && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 3000) begin
      checkOutput("byte_accept_timeout", 0, 1);
    end else begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic send_test_frame(input int k);
    applyStimulus(frame_byte(k, 0), frame_byte(k, 1), frame_byte(k, 2), frame_byte(k, 3));
  endtask

  // which: 0 = dac_start, 1 = underrun. at = cycle seen, -1 on timeout.
  task automatic wait_pulse(input int which, input int limit, input string tag, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if ((which == 0 && dac_start) || (which == 1 && underrun)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    enable     = 1'b0;
    byte_valid = 1'b0;
    byte_in    = '0;
    rate_div   = '1;
    #2 reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int s, s_prev, u, l0, st0, base, e_cyc;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    checkOutput("rst_data1", 32'(dac_data1), 0);
    checkOutput("rst_data2", 32'(dac_data2), 0);
    checkOutput("rst_start", 32'(dac_start), 0);
    checkOutput("rst_underrun", 32'(underrun), 0);
    checkOutput("rst_late", 32'(late), 0);
    checkOutput("rst_byte_ready", 32'(byte_ready), 0);
    checkOutput("rst_level", 32'(fifo_level), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_disabled", 32'(byte_ready), 0);

    // Basic frame
    $display("[TB] basic frame");
    rate_div = 16'd99;
    enable   = 1'b1;
    e_cyc    = cyc;
    applyStimulus(8'h34, 8'h12, 8'hCD, 8'hAB);
    checkOutput("basic_level_push", 32'(fifo_level), 1);
    wait_pulse(0, 300, "basic_start", s);
    checkOutput("basic_start_cycle", 32'(s - e_cyc), 100);
    checkOutput("basic_data1", 32'(dac_data1), 32'h124);
    checkOutput("basic_data2", 32'(dac_data2), 32'hABD);
    checkOutput("basic_level_pop", 32'(fifo_level), 0);

    // Pacing: 8 frames then underruns
    $display("[TB] pacing");
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 8; k++) send_test_frame(k);
    checkOutput("pace_level_loaded", 32'(fifo_level), 8);
    l0       = n_late;
    rate_div = 16'd199;
    s_prev   = 0;
    for (int k = 0; k < 8; k++) begin
      wait_pulse(0, 450, "pace_start", s);
      checkOutput($sformatf("pace_data_%0d", k), {8'h0, dac_data1, dac_data2}, {8'h0, frame_expect(k)});
      checkOutput($sformatf("pace_level_%0d", k), 32'(fifo_level), 32'(7 - k));
      if (k > 0) checkOutput($sformatf("pace_period_%0d", k), 32'(s - s_prev), 200);
      s_prev = s;
    end
    wait_pulse(1, 450, "pace_underrun", u);
    checkOutput("pace_underrun_gap", 32'(u - s_prev), 200);
    checkOutput("pace_hold", {8'h0, dac_data1, dac_data2}, {8'h0, frame_expect(7)});
    s_prev = u;
    wait_pulse(1, 450, "pace_underrun2", u);
    checkOutput("pace_underrun_gap2", 32'(u - s_prev), 200);
    checkOutput("pace_no_late", 32'(n_late - l0), 0);

    // Full FIFO: 17 frames with no ticks
    $display("[TB] full fifo");
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 16; k++) send_test_frame(k);
    checkOutput("full_level", 32'(fifo_level), 16);
    send_byte(frame_byte(16, 0));
    send_byte(frame_byte(16, 1));
    send_byte(frame_byte(16, 2));
    byte_in    = frame_byte(16, 3);
    byte_valid = 1'b1;
    #0;
    checkOutput("full_b3_blocked", 32'(byte_ready), 0);
    base     = played.size();
    rate_div = 16'd59;
    send_byte(frame_byte(16, 3));
    for (int i = 0; i < 1400 && played.size() < base + 17; i++) begin
      @(posedge clk); #1;
    end
    if (played.size() < base + 17) begin
      checkOutput("full_drain_timeout", 32'(played.size() - base), 17);
    end else begin
      for (int k = 0; k < 17; k++)
        checkOutput($sformatf("full_data_%0d", k), {8'h0, played[base + k]}, {8'h0, frame_expect(k)});
    end
    checkOutput("full_level_drained", 32'(fifo_level), 0);

    // Late ticks
    $display("[TB] late");
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 3; k++) send_test_frame(k);
    rate_div = 16'd10;
    wait_pulse(0, 100, "late_start1", s_prev);
    l0 = n_late;
    wait_pulse(0, 200, "late_start2", s);
    checkOutput("late_start_gap", 32'(s - s_prev), 44);
    checkOutput("late_pulses", 32'(n_late - l0), 3);
    checkOutput("late_data", {8'h0, dac_data1, dac_data2}, {8'h0, frame_expect(1)});
    checkOutput("late_violations", 32'(violations), 0);

    // Disable mid-stream and mid-conversion
    $display("[TB] disable");
    do_reset();
    enable = 1'b1;
    send_test_frame(0);
    send_test_frame(1);
    rate_div = 16'd20;
    wait_pulse(0, 100, "dis_start", s);
    send_byte(frame_byte(2, 0));
    send_byte(frame_byte(2, 1));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("dis_level_before", 32'(fifo_level), 1);
    st0    = n_start;
    enable = 1'b0;
    @(posedge clk); #1;
    checkOutput("dis_level_flushed", 32'(fifo_level), 0);
    checkOutput("dis_ready_low", 32'(byte_ready), 0);
    repeat (60) @(posedge clk);
    #1;
    checkOutput("dis_conv_done", 32'(dac_done), 1);
    checkOutput("dis_no_new_start", 32'(n_start - st0), 0);
    enable = 1'b1;
    send_test_frame(5);
    wait_pulse(0, 100, "dis_restart", s);
    checkOutput("dis_realigned", {8'h0, dac_data1, dac_data2}, {8'h0, frame_expect(5)});

    // Async reset in ACK
    $display("[TB] async reset");
    do_reset();
    enable = 1'b1;
    send_test_frame(3);
    send_test_frame(4);
    rate_div = 16'd5;
    wait_pulse(0, 100, "ar_start", s);
    #2;
    reset  = 1'b0;
    enable = 1'b0;
    #1;
    checkOutput("ar_data1", 32'(dac_data1), 0);
    checkOutput("ar_data2", 32'(dac_data2), 0);
    checkOutput("ar_start", 32'(dac_start), 0);
    checkOutput("ar_level", 32'(fifo_level), 0);
    checkOutput("ar_underrun", 32'(underrun), 0);
    checkOutput("ar_late", 32'(late), 0);
    checkOutput("ar_byte_ready", 32'(byte_ready), 0);
`ifdef DAC_SEQ_STATS_EN
    checkOutput("ar_underrun_count", 32'(underrun_count), 0);
    checkOutput("ar_late_count", 32'(late_count), 0);
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
